// File: rtl/mux8_rr_sched_pkg.sv
// Shared types and constants for the mux8_rr_sched round-robin scheduler.
package mux8_rr_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  // After reset the last owner is 7, so requester 0 is scanned first.
  localparam logic [SEL_W-1:0] PTR_RST = 3'd7;

endpackage

// File: rtl/mux8_rr_pick.sv
// Combinational rotating-priority picker: first set req bit scanning ptr+1 .. ptr+8 (mod 8).
module mux8_rr_pick
  import mux8_rr_sched_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               found,
  output logic [SEL_W-1:0]   idx,
  output logic [NUM_REQ-1:0] onehot
);

  logic [SEL_W-1:0] cand;
  logic             hit;

  // The eighth candidate wraps back to ptr itself, giving it lowest priority.
  always_comb begin
    found  = 1'b0;
    idx    = {SEL_W{1'b0}};
    cand   = ptr;
    hit    = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand  = ptr + SEL_W'(k);
      hit   = !found && req[cand];
      idx   = hit ? cand : idx;
      found = found | hit;
    end
    onehot = found ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << idx) : {NUM_REQ{1'b0}};
  end

endmodule

// File: rtl/mux8_rr_sched.sv
// Round-robin owner scheduler for the shared 8:1 single-bit mux, with registered data output.
// Optional owner hold limit compiled in by defining MUX8_SCHED_HOLD_LIMIT_EN.
module mux8_rr_sched
  import mux8_rr_sched_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] i,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic               dout,
  output logic               dout_vld
);

  if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_max_hold
    $error("mux8_rr_sched: MAX_HOLD must be in 1..15");
  end

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic               busy_q, busy_d;
  logic               dout_q, dout_d;
  logic               dout_vld_q, dout_vld_d;

  logic               hold_hit;
  logic               rel;
  logic [SEL_W-1:0]   pick_ptr;
  logic               pick_found;
  logic [SEL_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_onehot;

  // While owning, arbitration is only consumed on release, where the owner becomes the new pointer.
  assign rel      = (state_q == OWN) && (!req[sel_q] || hold_hit);
  assign pick_ptr = (state_q == OWN) ? sel_q : ptr_q;

  mux8_rr_pick u_pick (
    .req    (req),
    .ptr    (pick_ptr),
    .found  (pick_found),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

`ifdef MUX8_SCHED_HOLD_LIMIT_EN
  logic [3:0] cnt_q, cnt_d;

  assign hold_hit = (cnt_q == 4'(MAX_HOLD));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = pick_found ? 4'd1 : cnt_q;
    end else if (rel) begin
      cnt_d = pick_found ? 4'd1 : 4'd0;
    end else begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign hold_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    sel_d      = sel_q;
    busy_d     = busy_q;
    ptr_d      = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = OWN;
          grant_d = pick_onehot;
          sel_d   = pick_idx;
          busy_d  = 1'b1;
        end else begin
          grant_d = {NUM_REQ{1'b0}};
          busy_d  = 1'b0;
        end
      end
      OWN: begin
        if (rel) begin
          ptr_d = sel_q;
          if (pick_found) begin
            grant_d = pick_onehot;
            sel_d   = pick_idx;
            busy_d  = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = {NUM_REQ{1'b0}};
            busy_d  = 1'b0;
          end
        end else begin
          state_d = OWN;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = {NUM_REQ{1'b0}};
        busy_d  = 1'b0;
      end
    endcase
    // Data beat follows the grant by one cycle; dout holds while idle.
    dout_d     = busy_q ? i[sel_q] : dout_q;
    dout_vld_d = busy_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= {NUM_REQ{1'b0}};
      sel_q      <= {SEL_W{1'b0}};
      ptr_q      <= PTR_RST;
      busy_q     <= 1'b0;
      dout_q     <= 1'b0;
      dout_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      busy_q     <= busy_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
    end
  end

  assign grant    = grant_q;
  assign sel      = sel_q;
  assign busy     = busy_q;
  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Scoreboard bench for mux8_rr_sched: directed steps push expected outputs, a monitor pops and compares.
module tb_mux8_rr_sched;

  typedef struct packed {
    logic [79:0] tag;
    logic [7:0]  grant;
    logic [2:0]  sel;
    logic        busy;
    logic        dout;
    logic        vld;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] i;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       busy;
  logic       dout;
  logic       dout_vld;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // expected-state model (grant is hand-supplied per step)
  logic [7:0] m_grant = 8'h00;
  logic [2:0] m_sel   = 3'd0;
  logic       m_busy  = 1'b0;
  logic       m_dout  = 1'b0;
  logic       m_vld   = 1'b0;

  mux8_rr_sched #(.MAX_HOLD(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .i        (i),
    .grant    (grant),
    .sel      (sel),
    .busy     (busy),
    .dout     (dout),
    .dout_vld (dout_vld)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] enc(input logic [7:0] g);
    logic [2:0] r;
    r = 3'd0;
    for (int k = 0; k < 8; k++) if (g[k]) r = 3'(k);
    return r;
  endfunction

  // Drive inputs for the next edge and push the outputs expected after it.
  task automatic step(input logic r, input logic [7:0] rq, input logic [7:0] din,
                      input logic [7:0] eg, input logic [79:0] tag);
    exp_t e;
    @(posedge clk);
    #2;
    rst = r;
    req = rq;
    i   = din;
    if (r) begin
      m_grant = 8'h00; m_sel = 3'd0; m_busy = 1'b0; m_dout = 1'b0; m_vld = 1'b0;
    end else begin
      m_dout  = m_busy ? din[m_sel] : m_dout;
      m_vld   = m_busy;
      m_grant = eg;
      m_busy  = (eg != 8'h00);
      if (m_busy) m_sel = enc(eg);
    end
    e.tag = tag; e.grant = m_grant; e.sel = m_sel; e.busy = m_busy; e.dout = m_dout; e.vld = m_vld;
    exp_q.push_back(e);
  endtask

  // Monitor: one expected entry per clock, checked 1 ns after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (grant !== e.grant || sel !== e.sel || busy !== e.busy ||
            dout !== e.dout || dout_vld !== e.vld) begin
          failures++;
          $display("FAIL %s: got grant=%h sel=%0d busy=%b dout=%b vld=%b, want grant=%h sel=%0d busy=%b dout=%b vld=%b",
                   e.tag, grant, sel, busy, dout, dout_vld, e.grant, e.sel, e.busy, e.dout, e.vld);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    req = 8'h00;
    i   = 8'h00;
    step(1'b1, 8'h00, 8'h00, 8'h00, "rst0");
    step(1'b1, 8'h00, 8'h00, 8'h00, "rst1");

    // single requester 0: grant after edge 1, data after edge 2
    step(1'b0, 8'h01, 8'h01, 8'h01, "t1_grant");
    step(1'b0, 8'h01, 8'h01, 8'h01, "t1_data");
    step(1'b0, 8'h00, 8'h01, 8'h00, "t1_rel");
    step(1'b0, 8'h00, 8'h00, 8'h00, "t1_idle");

    // owner 3 drops while 7 waits; then 7 drops while 3 waits
    step(1'b0, 8'h08, 8'hA5, 8'h08, "t3_g3");
    step(1'b0, 8'h88, 8'h5A, 8'h08, "t3_h3");
    step(1'b0, 8'h80, 8'hF0, 8'h80, "t3_g7");
    step(1'b0, 8'h88, 8'h0F, 8'h80, "t3_h7");
    step(1'b0, 8'h08, 8'h8F, 8'h08, "t3_g3b");
    step(1'b0, 8'h00, 8'h08, 8'h00, "t3_rel");
    step(1'b0, 8'h00, 8'h00, 8'h00, "t3_idle");

    // reset mid-grant of owner 6, then pointer restarts at 7
    step(1'b0, 8'h40, 8'h40, 8'h40, "t6_g6");
    step(1'b0, 8'h40, 8'h40, 8'h40, "t6_h6");
    step(1'b1, 8'h40, 8'h40, 8'h00, "t6_rst");
    step(1'b0, 8'h41, 8'h41, 8'h01, "t6_g0");
    step(1'b0, 8'h40, 8'h41, 8'h40, "t6_g6b");
    step(1'b0, 8'h00, 8'h41, 8'h00, "t6_rel");
    step(1'b0, 8'h00, 8'h00, 8'h00, "t6_idle");

`ifndef MUX8_SCHED_HOLD_LIMIT_EN
    // no hold limit: owner 2 keeps grant until it drops
    for (int c = 0; c < 20; c++) step(1'b0, 8'h24, 8'h04, 8'h04, "t4_hold2");
    step(1'b0, 8'h20, 8'h20, 8'h20, "t4_g5");
    step(1'b0, 8'h00, 8'h20, 8'h00, "t4_rel");
    step(1'b0, 8'h00, 8'h00, 8'h00, "t4_idle");
`else
    // MAX_HOLD=4: full rotation with no idle cycles between owners
    step(1'b1, 8'h00, 8'h00, 8'h00, "t2_rst");
    for (int o = 0; o < 9; o++) begin
      for (int c = 0; c < 4; c++) begin
        step(1'b0, 8'hFF, 8'h55, 8'h01 << (o % 8), "t2_rot");
      end
    end
    step(1'b0, 8'h00, 8'h55, 8'h00, "t2_rel");
    // sole requester 5 is re-granted across hold-limit releases
    for (int c = 0; c < 10; c++) step(1'b0, 8'h20, 8'h20, 8'h20, "t5_sole");
    step(1'b0, 8'h00, 8'h00, 8'h00, "t5_rel");
`endif

    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
